// File: rtl/dmem_align_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_align_ctrl
//
// Data-memory access controller between the CPU load/store port and a
// word-organised synchronous data SRAM. Byte, half and word accesses at any
// byte address become word-wide SRAM transactions with byte enables. An access
// that crosses a word boundary is split into two SRAM accesses, and the CPU is
// stalled until it completes. Load data is sign- or zero-extended and returned
// through a register.
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset         synchronous, active-high reset
//   cpu_rd_en     load request (level, held until cpu_done)
//   cpu_wr_en     store request (level, held until cpu_done)
//   cpu_addr      byte address
//   cpu_sz        00 byte, 01 half, 10 word, 11 illegal
//   cpu_unsigned  zero-extend load data
//   cpu_din       store data, right-justified
//   cpu_dout      extended load data, registered
//   cpu_stall     CPU must hold PC and request
//   cpu_done      access completes this cycle
//   cpu_err       illegal request, asserted together with cpu_done
//   mem_en        SRAM access strobe
//   mem_we        SRAM write
//   mem_addr      SRAM word address
//   mem_be        byte enables, bit i = byte lane i
//   mem_wdata     lane-aligned write data
//   mem_rdata     SRAM read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module dmem_align_ctrl #(
  parameter int DMEM_DEPTH      = 1024,
  parameter int WORD_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH      = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_rd_en,
  input  logic                       cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0]      cpu_addr,
  input  logic [1:0]                 cpu_sz,
  input  logic                       cpu_unsigned,
  input  logic [31:0]                cpu_din,
  output logic [31:0]                cpu_dout,
  output logic                       cpu_stall,
  output logic                       cpu_done,
  output logic                       cpu_err,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [WORD_ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]                 mem_be,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    WR_HI = 2'd3
  } state_t;

  localparam logic [WORD_ADDR_WIDTH-1:0] LAST_WORD = WORD_ADDR_WIDTH'(DMEM_DEPTH - 1);

  state_t state_q, state_d;

  // Request fields held for the second half of a multi-cycle access.
  logic [1:0]                 off_q;
  logic [1:0]                 sz_q;
  logic                       uns_q;
  logic                       split_q;
  logic [WORD_ADDR_WIDTH-1:0] addr_hi_q;
  logic [3:0]                 be_hi_q;
  logic [31:0]                wdata_hi_q;
  logic [31:0]                lo_buf;
  logic [31:0]                dout_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [1:0]                 off;
  logic [2:0]                 nbytes;
  logic [3:0]                 mask;
  logic                       split;
  logic [WORD_ADDR_WIDTH-1:0] addr_lo;
  logic [WORD_ADDR_WIDTH-1:0] addr_hi;
  logic [7:0]                 be_wide;
  logic [63:0]                wdata_wide;
  logic                       req;
  logic                       illegal;

  always_comb begin
    off     = cpu_addr[1:0];
    addr_lo = cpu_addr[ADDR_WIDTH-1:2];
    // The word after the last one is word 0.
    addr_hi = (addr_lo == LAST_WORD) ? '0 : addr_lo + 1'b1;

    case (cpu_sz)
      2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
      default: begin nbytes = 3'd4; mask = 4'b1111; end
    endcase

    split = ({1'b0, off} + nbytes) > 3'd4;

    // Shifting into a double-width field yields both halves at once: the low
    // nibble/word is the first access, the high part is what spills into the
    // next word (mask >> (4-off), din >> 8*(4-off)).
    be_wide    = {4'b0000, mask} << off;
    wdata_wide = {32'h0, cpu_din} << {off, 3'b000};

    req     = cpu_rd_en | cpu_wr_en;
    illegal = req & ((cpu_sz == 2'b11) | (cpu_rd_en & cpu_wr_en));
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] extend(input logic [1:0]  sz,
                                         input logic        uns,
                                         input logic [31:0] raw);
    case (sz)
      2'b00:   extend = {{24{raw[7]  & ~uns}}, raw[7:0]};
      2'b01:   extend = {{16{raw[15] & ~uns}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  logic [63:0] rd_window;
  logic [63:0] rd_shifted;
  logic [31:0] rd_ext;

  always_comb begin
    // An unsplit load only ever sees one word; a split load combines the
    // buffered low word with the word arriving now.
    rd_window  = split_q ? {mem_rdata, lo_buf} : {32'h0, mem_rdata};
    rd_shifted = rd_window >> {off_q, 3'b000};
    rd_ext     = extend(sz_q, uns_q, rd_shifted[31:0]);
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  logic latch_req;
  logic capture_lo;
  logic load_dout;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    latch_req  = 1'b0;
    capture_lo = 1'b0;
    load_dout  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = 32'h0;
    cpu_done   = 1'b0;
    cpu_err    = 1'b0;

    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (illegal) begin
            cpu_done = 1'b1;
            cpu_err  = 1'b1;
          end else if (cpu_rd_en) begin
            mem_en    = 1'b1;
            mem_addr  = addr_lo;
            latch_req = 1'b1;
            state_d   = RD_LO;
          end else if (cpu_wr_en) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_lo;
            mem_be    = be_wide[3:0];
            mem_wdata = wdata_wide[31:0];
            if (split) begin
              latch_req = 1'b1;
              state_d   = WR_HI;
            end else begin
              cpu_done = 1'b1;
            end
          end
        end

        RD_LO: begin
          if (split_q) begin
            capture_lo = 1'b1;
            mem_en     = 1'b1;
            mem_addr   = addr_hi_q;
            state_d    = RD_HI;
          end else begin
            load_dout = 1'b1;
            cpu_done  = 1'b1;
            state_d   = IDLE;
          end
        end

        RD_HI: begin
          load_dout = 1'b1;
          cpu_done  = 1'b1;
          state_d   = IDLE;
        end

        WR_HI: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_hi_q;
          mem_be    = be_hi_q;
          mem_wdata = wdata_hi_q;
          cpu_done  = 1'b1;
          state_d   = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end

    cpu_stall = ~reset & req & ~cpu_done;
  end

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      // NOTE: lo_buf and the other data registers are cleared too; an
      // abandoned split load must leave nothing behind that could leak into a
      // later result.
      state_q    <= IDLE;
      off_q      <= 2'b00;
      sz_q       <= 2'b00;
      uns_q      <= 1'b0;
      split_q    <= 1'b0;
      addr_hi_q  <= '0;
      be_hi_q    <= 4'b0000;
      wdata_hi_q <= 32'h0;
      lo_buf     <= 32'h0;
      dout_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        off_q      <= off;
        sz_q       <= cpu_sz;
        uns_q      <= cpu_unsigned;
        split_q    <= split;
        addr_hi_q  <= addr_hi;
        be_hi_q    <= be_wide[7:4];
        wdata_hi_q <= wdata_wide[63:32];
      end
      if (capture_lo) begin
        lo_buf <= mem_rdata;
      end
      if (load_dout) begin
        dout_q <= rd_ext;
      end
    end
  end

  assign cpu_dout = dout_q;

endmodule

// File: tb/tb_dmem_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_align_ctrl
//
// Self-checking bench for dmem_align_ctrl. A behavioural word SRAM is attached
// to the memory port. Expected load values come from a byte-addressed
// reference memory. Expected latencies come from the split rule.
// -----------------------------------------------------------------------------
module tb_dmem_align_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_rd_en;
  logic        cpu_wr_en;
  logic [11:0] cpu_addr;
  logic [1:0]  cpu_sz;
  logic        cpu_unsigned;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        cpu_done;
  logic        cpu_err;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  dmem_align_ctrl #(
    .DMEM_DEPTH     (1024),
    .WORD_ADDR_WIDTH(10),
    .ADDR_WIDTH     (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_rd_en   (cpu_rd_en),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_addr    (cpu_addr),
    .cpu_sz      (cpu_sz),
    .cpu_unsigned(cpu_unsigned),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_stall   (cpu_stall),
    .cpu_done    (cpu_done),
    .cpu_err     (cpu_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with a backdoor write port for preloading.
  logic [31:0] sram [1024];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      sram[bd_addr] <= bd_data;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Reference memory: flat byte array, byte address wraps modulo 4096.
  logic [7:0] ref_mem [4096];

  function automatic logic [31:0] ref_load(input logic [11:0] addr,
                                           input logic [1:0] sz,
                                           input logic uns);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 4096];
    if (sz == 2'b00 && !uns && v[7])  v = v | 32'hFFFF_FF00;
    if (sz == 2'b01 && !uns && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [11:0] addr, input logic [1:0] sz, input logic [31:0] din);
    for (int i = 0; i < (1 << sz); i++) ref_mem[(int'(addr) + i) % 4096] = din[8*i +: 8];
  endtask

  function automatic int exp_cycles(input logic rd, input logic [11:0] addr, input logic [1:0] sz);
    logic sp;
    sp = (int'(addr[1:0]) + (1 << sz)) > 4;
    if (rd) return sp ? 3 : 2;
    return sp ? 2 : 1;
  endfunction

  // Called at posedge+1; returns at posedge+1.
  task automatic set_word(input logic [9:0] w, input logic [31:0] val);
    bd_we = 1'b1; bd_addr = w; bd_data = val;
    for (int i = 0; i < 4; i++) ref_mem[4*int'(w) + i] = val[8*i +: 8];
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Per-cycle record of the last access.
  logic        cyc_en    [8];
  logic        cyc_we    [8];
  logic [9:0]  cyc_addr  [8];
  logic [3:0]  cyc_be    [8];
  logic [31:0] cyc_wdata [8];
  logic        cyc_stall [8];
  logic        cyc_done  [8];
  int          n_cyc;
  logic        got_err;

  // Drives one request at posedge+1, samples each cycle on the negedge until
  // cpu_done, then drops the request after the done edge.
  task automatic access(input logic rd, input logic wr, input logic [11:0] addr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] din);
    logic timed_out;
    cpu_rd_en = rd; cpu_wr_en = wr; cpu_addr = addr;
    cpu_sz = sz; cpu_unsigned = uns; cpu_din = din;
    n_cyc = 0; got_err = 1'b0; timed_out = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cyc_en[c] = mem_en; cyc_we[c] = mem_we; cyc_addr[c] = mem_addr;
      cyc_be[c] = mem_be; cyc_wdata[c] = mem_wdata;
      cyc_stall[c] = cpu_stall; cyc_done[c] = cpu_done;
      n_cyc = c + 1;
      if (cpu_done) begin
        got_err = cpu_err;
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    if (timed_out) begin
      checks++; failures++;
      $display("FAIL timeout: no cpu_done within 8 cycles (addr=%h sz=%b rd=%b wr=%b)", addr, sz, rd, wr);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    logic [73:0] outs;
    reset = 1'b1;
    cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 12'h014; cpu_sz = 2'b10;
    cpu_unsigned = 1'b0; cpu_din = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {mem_en, mem_we, mem_addr, mem_be, mem_wdata, cpu_done, cpu_stall, cpu_err, 1'b0};
    checks++;
    if (outs !== 74'h0) begin failures++; $display("FAIL reset_outputs: got %h want 0", outs); end
    checks++;
    if (cpu_dout !== 32'h0) begin failures++; $display("FAIL reset_dout: got %h want 0", cpu_dout); end
    cpu_rd_en = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < 1024; w++) set_word(10'(w), $urandom);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_load;
    set_word(10'd5, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 12'h014, 2'b10, 1'b0, 32'h0);
    checks++;
    if (!(cyc_en[0] === 1'b1 && cyc_we[0] === 1'b0 && cyc_addr[0] === 10'd5)) begin
      failures++; $display("FAIL lw_read_issue: en=%b we=%b addr=%0d want 1/0/5", cyc_en[0], cyc_we[0], cyc_addr[0]);
    end
    checks++;
    if (n_cyc !== 2) begin failures++; $display("FAIL lw_latency: got %0d cycles want 2", n_cyc); end
    checks++;
    if ({cyc_stall[0], cyc_stall[1]} !== 2'b10) begin
      failures++; $display("FAIL lw_stall: got %b%b want 10", cyc_stall[0], cyc_stall[1]);
    end
    checks++;
    if (cpu_dout !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data: got %h want deadbeef", cpu_dout); end
  endtask

  task automatic test_byte_ext;
    set_word(10'd2, 32'h80FF_1234);
    access(1'b1, 1'b0, 12'h00B, 2'b00, 1'b0, 32'h0);
    checks++;
    if (cpu_dout !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sign: got %h want ffffff80", cpu_dout); end
    access(1'b1, 1'b0, 12'h00B, 2'b00, 1'b1, 32'h0);
    checks++;
    if (cpu_dout !== 32'h0000_0080) begin failures++; $display("FAIL lbu_zero: got %h want 00000080", cpu_dout); end
  endtask

  task automatic test_split_load;
    set_word(10'd3, 32'h4433_2211);
    set_word(10'd4, 32'h8877_6655);
    access(1'b1, 1'b0, 12'h00F, 2'b10, 1'b0, 32'h0);
    checks++;
    if (!(cyc_en[0] === 1'b1 && cyc_addr[0] === 10'd3 && cyc_en[1] === 1'b1 && cyc_we[1] === 1'b0 && cyc_addr[1] === 10'd4)) begin
      failures++; $display("FAIL split_ld_addrs: got %0d,%0d want 3,4", cyc_addr[0], cyc_addr[1]);
    end
    checks++;
    if (n_cyc !== 3) begin failures++; $display("FAIL split_ld_latency: got %0d cycles want 3", n_cyc); end
    checks++;
    if (cpu_dout !== 32'h7766_5544) begin failures++; $display("FAIL split_lw_data: got %h want 77665544", cpu_dout); end
    access(1'b1, 1'b0, 12'h00F, 2'b01, 1'b0, 32'h0);
    checks++;
    if (cpu_dout !== 32'h0000_5544) begin failures++; $display("FAIL split_lh_data: got %h want 00005544", cpu_dout); end
  endtask

  task automatic test_split_store;
    access(1'b0, 1'b1, 12'h00E, 2'b10, 1'b0, 32'hAABB_CCDD);
    ref_store(12'h00E, 2'b10, 32'hAABB_CCDD);
    checks++;
    if (!(cyc_en[0] === 1'b1 && cyc_we[0] === 1'b1 && cyc_addr[0] === 10'd3 && cyc_be[0] === 4'b1100 &&
          cyc_wdata[0] === 32'hCCDD_0000 && cyc_done[0] === 1'b0)) begin
      failures++; $display("FAIL split_st_lo: addr=%0d be=%b wdata=%h done=%b want 3/1100/ccdd0000/0",
                           cyc_addr[0], cyc_be[0], cyc_wdata[0], cyc_done[0]);
    end
    checks++;
    if (!(n_cyc === 2 && cyc_en[1] === 1'b1 && cyc_we[1] === 1'b1 && cyc_addr[1] === 10'd4 &&
          cyc_be[1] === 4'b0011 && cyc_wdata[1] === 32'h0000_AABB)) begin
      failures++; $display("FAIL split_st_hi: cycles=%0d addr=%0d be=%b wdata=%h want 2/4/0011/0000aabb",
                           n_cyc, cyc_addr[1], cyc_be[1], cyc_wdata[1]);
    end
    checks++;
    if (sram[3] !== 32'hCCDD_2211 || sram[4] !== 32'h8877_AABB) begin
      failures++; $display("FAIL split_st_mem: got %h %h want ccdd2211 8877aabb", sram[3], sram[4]);
    end
  endtask

  task automatic test_wrap_reset;
    logic [31:0] word0;
    logic [73:0] outs;
    word0 = sram[0];
    cpu_wr_en = 1'b1; cpu_rd_en = 1'b0; cpu_addr = 12'hFFF; cpu_sz = 2'b01;
    cpu_unsigned = 1'b0; cpu_din = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === 10'd1023 && mem_be === 4'b1000 &&
          mem_wdata === 32'h3400_0000 && cpu_done === 1'b0 && cpu_stall === 1'b1)) begin
      failures++; $display("FAIL wrap_st_lo: addr=%0d be=%b wdata=%h done=%b want 1023/1000/34000000/0",
                           mem_addr, mem_be, mem_wdata, cpu_done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    outs = {mem_en, mem_we, mem_addr, mem_be, mem_wdata, cpu_done, cpu_stall, cpu_err, 1'b0};
    checks++;
    if (outs !== 74'h0) begin failures++; $display("FAIL wrap_reset_outputs: got %h want 0", outs); end
    @(posedge clk); #1;
    reset = 1'b0; cpu_wr_en = 1'b0;
    ref_mem[12'hFFF] = 8'h34;
    @(negedge clk);
    checks++;
    if (cpu_dout !== 32'h0 || mem_en !== 1'b0) begin
      failures++; $display("FAIL wrap_after_reset: dout=%h mem_en=%b want 0/0", cpu_dout, mem_en);
    end
    checks++;
    if (sram[0] !== word0 || sram[1023][31:24] !== 8'h34) begin
      failures++; $display("FAIL wrap_mem: word0=%h want %h, byte fff=%h want 34", sram[0], word0, sram[1023][31:24]);
    end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 12'hFFE, 2'b01, 1'b1, 32'h0);
    checks++;
    if (n_cyc !== 2 || cpu_dout !== ref_load(12'hFFE, 2'b01, 1'b1)) begin
      failures++; $display("FAIL wrap_idle_load: cycles=%0d dout=%h want 2/%h", n_cyc, cpu_dout, ref_load(12'hFFE, 2'b01, 1'b1));
    end
  endtask

  task automatic test_illegal;
    logic [31:0] prev;
    prev = cpu_dout;
    access(1'b1, 1'b0, 12'h020, 2'b11, 1'b0, 32'h0);
    checks++;
    if (!(n_cyc === 1 && got_err === 1'b1 && cyc_en[0] === 1'b0 && cyc_stall[0] === 1'b0)) begin
      failures++; $display("FAIL illegal_sz: cycles=%0d err=%b mem_en=%b stall=%b want 1/1/0/0",
                           n_cyc, got_err, cyc_en[0], cyc_stall[0]);
    end
    checks++;
    if (cpu_dout !== prev) begin failures++; $display("FAIL illegal_dout: got %h want %h", cpu_dout, prev); end
    access(1'b1, 1'b1, 12'h020, 2'b10, 1'b0, 32'h0);
    checks++;
    if (!(n_cyc === 1 && got_err === 1'b1 && cyc_en[0] === 1'b0)) begin
      failures++; $display("FAIL illegal_rdwr: cycles=%0d err=%b mem_en=%b want 1/1/0", n_cyc, got_err, cyc_en[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic        rd;
    logic [1:0]  sz;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] din;
    logic [31:0] exp_val;
    int          exp_cyc;
    for (int k = 0; k < 300; k++) begin
      rd   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 2));
      uns  = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63)) : 12'($urandom_range(0, 4095));
      din  = $urandom;
      exp_val = ref_load(addr, sz, uns);
      exp_cyc = exp_cycles(rd, addr, sz);
      access(rd, ~rd, addr, sz, uns, din);
      checks++;
      if (n_cyc !== exp_cyc || got_err !== 1'b0) begin
        failures++; $display("FAIL rand_latency[%0d]: rd=%b addr=%h sz=%b cycles=%0d err=%b want %0d/0",
                             k, rd, addr, sz, n_cyc, got_err, exp_cyc);
      end
      if (rd) begin
        checks++;
        if (cpu_dout !== exp_val) begin
          failures++; $display("FAIL rand_load[%0d]: addr=%h sz=%b uns=%b got %h want %h", k, addr, sz, uns, cpu_dout, exp_val);
        end
      end else begin
        ref_store(addr, sz, din);
      end
    end
    for (int w = 0; w < 1024; w++) begin
      checks++;
      if (sram[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) begin
        failures++; $display("FAIL mem_image[%0d]: got %h want %h", w, sram[w],
                             {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
      end
    end
  endtask

  initial begin
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; mem_rdata = '0;
    test_reset();
    test_aligned_load();
    test_byte_ext();
    test_split_load();
    test_split_store();
    test_wrap_reset();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
